manager_client_mux: RTL and testbench



---
 rtl/manager_pkg.sv | 53 +++++
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/manager_client_mux.sv | 156 +++++++++++++++
 tb/tb_manager_client_mux.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manager_pkg.sv
// manager_pkg: shared helpers for the manager-channel client mux.
//   clog2 / id_width / cnt_width : width derivations used by the mux and arbiter
//   tag_pack / tag_id / tag_payload : {id, payload} tag helpers, id in the MSBs
// Tags are handled as 64-bit vectors; callers cast to their real width.
package manager_pkg;

  localparam int unsigned TAG_MAX_W = 64;

  typedef logic [TAG_MAX_W-1:0] tag_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Client-id width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

  // Width able to hold 0..m inclusive.
  function automatic int unsigned cnt_width(input int unsigned m);
    return clog2(m + 1);
  endfunction

  // Low-w-bits mask.
  function automatic tag_t tag_mask(input int unsigned w);
    return (w >= TAG_MAX_W) ? '1 : ((tag_t'(1) << w) - tag_t'(1));
  endfunction

  // Build {id, payload} with a pay_w-bit payload field.
  function automatic tag_t tag_pack(input tag_t id, input tag_t payload,
                                    input int unsigned pay_w);
    return (id << pay_w) | (payload & tag_mask(pay_w));
  endfunction

  // Extract the id field sitting above a pay_w-bit payload.
  function automatic tag_t tag_id(input tag_t tag, input int unsigned pay_w,
                                  input int unsigned id_w);
    return (tag >> pay_w) & tag_mask(id_w);
  endfunction

  // Extract the pay_w-bit payload field.
  function automatic tag_t tag_payload(input tag_t tag, input int unsigned pay_w);
    return tag & tag_mask(pay_w);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, first requester at or after ptr wins.
//   i_clk, i_rst : clock, async active-high reset (ptr -> 0)
//   req          : per-requester request
//   en           : grant enable; ptr only advances on an enabled grant
//   grant        : one-hot grant, zero when !en or no request (combinational)
//   grant_idx    : index of the winning requester (combinational)
module rr_arbiter
  import manager_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N-1:0]             req,
  input  logic                     en,
  output logic [N-1:0]             grant,
  output logic [id_width(N)-1:0]   grant_idx
);

  localparam int unsigned IDX_W = id_width(N);

  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     grant_raw_c;
  logic [IDX_W-1:0] idx_c;
  logic             found_c;

  // Two passes: indices at/above ptr first, then the wrapped ones below it.
  always_comb begin
    grant_raw_c = '0;
    idx_c       = '0;
    found_c     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_c && req[i] && (i >= 32'(ptr))) begin
        found_c        = 1'b1;
        grant_raw_c[i] = 1'b1;
        idx_c          = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_c && req[i] && (i < 32'(ptr))) begin
        found_c        = 1'b1;
        grant_raw_c[i] = 1'b1;
        idx_c          = IDX_W'(i);
      end
    end
  end

  assign grant     = en ? grant_raw_c : '0;
  assign grant_idx = idx_c;

  // Pointer moves just past the winner; holds when nothing is granted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (en && found_c) begin
      ptr <= (32'(idx_c) == (N - 1)) ? '0 : (idx_c + IDX_W'(1));
    end
  end

endmodule

// File: rtl/manager_client_mux.sv
// manager_client_mux: merges client alloc requests into one tagged stream and
// routes tagged alloc replies back to the issuing client.
//   i_clk, i_rst                    : clock, async active-high reset
//   c_req_vld/c_req_data/c_req_rdy  : per-client request ports (rdy one-hot or 0)
//   m_req_vld/m_req_data/m_req_rdy  : merged request {id, payload}, registered
//   s_rep_vld/s_rep_data/s_rep_rdy  : tagged reply {id, payload} from the channel
//   c_rep_vld/c_rep_data/c_rep_rdy  : per-client reply valid/ready, shared payload
//   o_rep_err                       : registered pulse on a bad-id or unexpected reply
module manager_client_mux
  import manager_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS     = 4,
  parameter int unsigned REQ_W           = 8,
  parameter int unsigned REP_W           = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [NUM_CLIENTS-1:0]                c_req_vld,
  input  logic [NUM_CLIENTS*REQ_W-1:0]          c_req_data,
  output logic [NUM_CLIENTS-1:0]                c_req_rdy,
  output logic                                  m_req_vld,
  output logic [id_width(NUM_CLIENTS)+REQ_W-1:0] m_req_data,
  input  logic                                  m_req_rdy,
  input  logic                                  s_rep_vld,
  input  logic [id_width(NUM_CLIENTS)+REP_W-1:0] s_rep_data,
  output logic                                  s_rep_rdy,
  output logic [NUM_CLIENTS-1:0]                c_rep_vld,
  output logic [REP_W-1:0]                      c_rep_data,
  input  logic [NUM_CLIENTS-1:0]                c_rep_rdy,
  output logic                                  o_rep_err
);

  localparam int unsigned ID_W      = id_width(NUM_CLIENTS);
  localparam int unsigned CNT_W     = cnt_width(MAX_OUTSTANDING);
  localparam int unsigned TAG_REQ_W = ID_W + REQ_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]       cnt [NUM_CLIENTS];

  logic                   load_c;
  logic [NUM_CLIENTS-1:0] elig_c;
  logic [NUM_CLIENTS-1:0] grant_c;
  logic [ID_W-1:0]        grant_idx_c;
  logic                   grant_any_c;
  logic [REQ_W-1:0]       grant_payload_c;
  logic [TAG_REQ_W-1:0]   req_tag_c;

  logic [ID_W-1:0]        rep_id_c;
  logic                   rep_id_ok_c;
  logic                   rep_cnt_zero_c;
  logic                   rep_hs_c;
  logic                   rep_err_c;
  logic [NUM_CLIENTS-1:0] cnt_inc_c;
  logic [NUM_CLIENTS-1:0] cnt_dec_c;

  // Holding register can take a new request when empty or draining this cycle.
  assign load_c = !m_req_vld || m_req_rdy;

  // A client at its outstanding limit is not offered to the arbiter.
  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      elig_c[i] = c_req_vld[i] && (cnt[i] != CNT_MAX);
    end
  end

  rr_arbiter #(
    .N (NUM_CLIENTS)
  ) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .req       (elig_c),
    .en        (load_c),
    .grant     (grant_c),
    .grant_idx (grant_idx_c)
  );

  assign c_req_rdy   = grant_c;
  assign grant_any_c = |grant_c;

  // Payload of the granted client (grant_c is one-hot or zero).
  always_comb begin
    grant_payload_c = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_c[i]) grant_payload_c = c_req_data[i*REQ_W +: REQ_W];
    end
  end

  assign req_tag_c = TAG_REQ_W'(tag_pack(tag_t'(grant_idx_c), tag_t'(grant_payload_c), REQ_W));

  // Request holding register; data only changes on a grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_req_vld  <= 1'b0;
      m_req_data <= '0;
    end else if (load_c) begin
      m_req_vld <= grant_any_c;
      if (grant_any_c) m_req_data <= req_tag_c;
    end
  end

  // Reply decode; an out-of-range id is accepted and dropped.
  always_comb begin
    rep_id_c       = ID_W'(tag_id(tag_t'(s_rep_data), REP_W, ID_W));
    rep_id_ok_c    = 32'(rep_id_c) < NUM_CLIENTS;
    c_rep_vld      = '0;
    s_rep_rdy      = 1'b1;
    rep_cnt_zero_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (32'(rep_id_c) == i) begin
        c_rep_vld[i]   = s_rep_vld;
        s_rep_rdy      = c_rep_rdy[i];
        rep_cnt_zero_c = (cnt[i] == '0);
      end
    end
  end

  assign c_rep_data = REP_W'(tag_payload(tag_t'(s_rep_data), REP_W));
  assign rep_hs_c   = s_rep_vld && s_rep_rdy;
  assign rep_err_c  = rep_hs_c && (!rep_id_ok_c || rep_cnt_zero_c);

  // Counter deltas; a reply to an idle client never underflows.
  always_comb begin
    cnt_inc_c = grant_c;
    cnt_dec_c = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      cnt_dec_c[i] = rep_hs_c && (32'(rep_id_c) == i) && (cnt[i] != '0);
    end
  end

  // Outstanding counters; simultaneous grant and reply cancel out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
        if (cnt_inc_c[i] && !cnt_dec_c[i]) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (cnt_dec_c[i] && !cnt_inc_c[i]) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Error pulse, one cycle after the offending reply handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rep_err <= 1'b0;
    end else begin
      o_rep_err <= rep_err_c;
    end
  end

endmodule

// File: tb/tb_manager_client_mux.sv
// tb_manager_client_mux: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the mux (5 clients, limit 2).
module tb_manager_client_mux;

  localparam int unsigned NC = 5;
  localparam int unsigned RW = 8;
  localparam int unsigned PW = 8;
  localparam int unsigned MO = 2;
  localparam int unsigned IW = 3;

  logic               i_clk;
  logic               i_rst;
  logic [NC-1:0]      c_req_vld;
  logic [NC*RW-1:0]   c_req_data;
  logic [NC-1:0]      c_req_rdy;
  logic               m_req_vld;
  logic [IW+RW-1:0]   m_req_data;
  logic               m_req_rdy;
  logic               s_rep_vld;
  logic [IW+PW-1:0]   s_rep_data;
  logic               s_rep_rdy;
  logic [NC-1:0]      c_rep_vld;
  logic [PW-1:0]      c_rep_data;
  logic [NC-1:0]      c_rep_rdy;
  logic               o_rep_err;

  int checks = 0;
  int errors = 0;

  // Reference state: who is held, where round-robin resumes, unreplied counts.
  int mdl_ptr;
  int mdl_cnt [NC];
  bit mdl_vld;
  int mdl_id;
  int mdl_pay;
  bit mdl_err;
  int acc_log [$];

  manager_client_mux #(
    .NUM_CLIENTS     (NC),
    .REQ_W           (RW),
    .REP_W           (PW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .c_req_vld  (c_req_vld),
    .c_req_data (c_req_data),
    .c_req_rdy  (c_req_rdy),
    .m_req_vld  (m_req_vld),
    .m_req_data (m_req_data),
    .m_req_rdy  (m_req_rdy),
    .s_rep_vld  (s_rep_vld),
    .s_rep_data (s_rep_data),
    .s_rep_rdy  (s_rep_rdy),
    .c_rep_vld  (c_rep_vld),
    .c_rep_data (c_rep_data),
    .c_rep_rdy  (c_rep_rdy),
    .o_rep_err  (o_rep_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mdl_ptr = 0;
    mdl_vld = 1'b0;
    mdl_id  = 0;
    mdl_pay = 0;
    mdl_err = 1'b0;
    for (int c = 0; c < NC; c++) mdl_cnt[c] = 0;
  endfunction

  // Client the model expects to win this cycle, -1 if none.
  function automatic int pick();
    if (mdl_vld && !m_req_rdy) return -1;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (mdl_ptr + k) % NC;
      if (c_req_vld[c] && (mdl_cnt[c] < MO)) return c;
    end
    return -1;
  endfunction

  function automatic logic [IW+RW-1:0] exp_tag(input int id, input int pay);
    return {IW'(id), RW'(pay)};
  endfunction

  // One clock: called just after a falling edge with inputs already driven.
  task automatic run_cycle();
    int g;
    int rid;
    bit rep_ok;
    bit hs;
    bit dec;
    logic [NC-1:0] exp_rdy;
    logic [NC-1:0] exp_rv;
    logic exp_srdy;
    #1;
    g = pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    rid = int'(s_rep_data[PW +: IW]);
    rep_ok = (rid < NC);
    exp_rv = '0;
    if (rep_ok) exp_rv[rid] = s_rep_vld;
    exp_srdy = rep_ok ? c_rep_rdy[rid] : 1'b1;
    check("c_req_rdy", 64'(c_req_rdy), 64'(exp_rdy));
    check("c_rep_vld", 64'(c_rep_vld), 64'(exp_rv));
    check("s_rep_rdy", 64'(s_rep_rdy), 64'(exp_srdy));
    check("c_rep_data", 64'(c_rep_data), 64'(s_rep_data[PW-1:0]));
    hs = s_rep_vld && exp_srdy;
    @(posedge i_clk);
    if (mdl_vld && m_req_rdy) acc_log.push_back(mdl_id);
    if (!mdl_vld || m_req_rdy) begin
      mdl_vld = (g >= 0);
      if (g >= 0) begin
        mdl_id  = g;
        mdl_pay = int'(c_req_data[g*RW +: RW]);
        mdl_ptr = (g + 1) % NC;
      end
    end
    mdl_err = hs && (!rep_ok || mdl_cnt[rid] == 0);
    dec = hs && rep_ok && (mdl_cnt[rid] > 0);
    if (g >= 0) mdl_cnt[g]++;
    if (dec) mdl_cnt[rid]--;
    #1;
    check("m_req_vld", 64'(m_req_vld), 64'(mdl_vld));
    if (mdl_vld) check("m_req_data", 64'(m_req_data), 64'(exp_tag(mdl_id, mdl_pay)));
    check("o_rep_err", 64'(o_rep_err), 64'(mdl_err));
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    c_req_vld  = '0;
    c_req_data = '0;
    m_req_rdy  = 1'b1;
    s_rep_vld  = 1'b0;
    s_rep_data = '0;
    c_rep_rdy  = '1;
  endtask

  task automatic set_reply(input int id, input int pay);
    s_rep_vld  = 1'b1;
    s_rep_data = {IW'(id), PW'(pay)};
  endtask

  // Empty the holding register and return every outstanding reply.
  task automatic drain();
    for (int n = 0; n < 12; n++) begin
      int r;
      r = -1;
      idle_inputs();
      for (int c = 0; c < NC; c++) if (r < 0 && mdl_cnt[c] > 0) r = c;
      if (r >= 0) set_reply(r, 8'h3C);
      run_cycle();
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_m_req_vld", 64'(m_req_vld), 64'(0));
    check("rst_m_req_data", 64'(m_req_data), 64'(0));
    check("rst_o_rep_err", 64'(o_rep_err), 64'(0));
    @(negedge i_clk);
    i_rst = 1'b0;

    // Fairness: everyone requests, every reply comes straight back.
    acc_log.delete();
    for (int n = 0; n < 15; n++) begin
      c_req_vld  = '1;
      c_req_data = NC*RW'({$urandom, $urandom});
      m_req_rdy  = 1'b1;
      c_rep_rdy  = '1;
      s_rep_vld  = 1'b0;
      s_rep_data = '0;
      if (mdl_vld) set_reply(mdl_id, n);
      run_cycle();
    end
    check("rr_count", 64'(acc_log.size()), 64'(14));
    for (int k = 0; k < acc_log.size(); k++) check("rr_order", 64'(acc_log[k]), 64'(k % NC));

    // Backpressure: client 2's 0xA5 held for 5 stalled cycles.
    drain();
    idle_inputs();
    c_req_vld = NC'(1 << 2);
    c_req_data[2*RW +: RW] = 8'hA5;
    run_cycle();
    acc_log.delete();
    for (int n = 0; n < 5; n++) begin
      c_req_vld = '1;
      m_req_rdy = 1'b0;
      #1;
      check("bp_c_req_rdy", 64'(c_req_rdy), 64'(0));
      run_cycle();
      check("bp_hold", 64'(m_req_data), 64'(exp_tag(2, 8'hA5)));
    end
    check("bp_no_xfer", 64'(acc_log.size()), 64'(0));
    c_req_vld = '0;
    m_req_rdy = 1'b1;
    run_cycle();
    check("bp_one_xfer", 64'(acc_log.size()), 64'(1));
    if (acc_log.size() > 0) check("bp_xfer_id", 64'(acc_log[0]), 64'(2));

    // Outstanding limit on client 1, then a reply frees a slot.
    drain();
    for (int n = 0; n < 3; n++) begin
      idle_inputs();
      c_req_vld = NC'(1 << 1);
      #1;
      check("lim_rdy", 64'(c_req_rdy[1]), 64'(n < 2));
      run_cycle();
    end
    idle_inputs();
    c_req_vld = NC'(1 << 1);
    set_reply(1, 8'h11);
    #1;
    check("lim_rdy_on_reply", 64'(c_req_rdy[1]), 64'(0));
    run_cycle();
    idle_inputs();
    c_req_vld = NC'(1 << 1);
    #1;
    check("lim_rdy_after_reply", 64'(c_req_rdy[1]), 64'(1));
    run_cycle();

    // Grant and reply to client 3 in the same cycle leave its count at 1.
    drain();
    idle_inputs();
    c_req_vld = NC'(1 << 3);
    run_cycle();
    c_req_vld = NC'(1 << 3);
    set_reply(3, 8'h33);
    #1;
    check("sim_rdy", 64'(c_req_rdy[3]), 64'(1));
    check("sim_srdy", 64'(s_rep_rdy), 64'(1));
    run_cycle();
    for (int n = 0; n < 2; n++) begin
      idle_inputs();
      c_req_vld = NC'(1 << 3);
      #1;
      check("sim_after_rdy", 64'(c_req_rdy[3]), 64'(n == 0));
      run_cycle();
    end

    // Bad reply id, then a reply to an idle client.
    drain();
    idle_inputs();
    c_rep_rdy = '0;
    set_reply(6, 8'h77);
    #1;
    check("bad_srdy", 64'(s_rep_rdy), 64'(1));
    check("bad_rep_vld", 64'(c_rep_vld), 64'(0));
    run_cycle();
    check("bad_err", 64'(o_rep_err), 64'(1));
    idle_inputs();
    run_cycle();
    check("bad_err_clear", 64'(o_rep_err), 64'(0));
    idle_inputs();
    set_reply(0, 8'h55);
    #1;
    check("idle_rep_vld", 64'(c_rep_vld), 64'(1));
    check("idle_rep_data", 64'(c_rep_data), 64'(8'h55));
    run_cycle();
    check("idle_err", 64'(o_rep_err), 64'(1));

    // Randomized traffic.
    drain();
    for (int n = 0; n < 1500; n++) begin
      c_req_vld  = NC'($urandom);
      c_req_data = NC*RW'({$urandom, $urandom});
      m_req_rdy  = ($urandom_range(0, 3) != 0);
      c_rep_rdy  = NC'($urandom);
      s_rep_vld  = 1'b0;
      s_rep_data = {IW'($urandom_range(0, 7)), PW'($urandom)};
      case ($urandom_range(0, 7))
        0: set_reply($urandom_range(NC, 7), $urandom);
        1, 2, 3, 4: begin
          int st;
          int r;
          st = $urandom_range(0, NC - 1);
          r = -1;
          for (int k = 0; k < NC; k++) begin
            if (r < 0 && mdl_cnt[(st + k) % NC] > 0) r = (st + k) % NC;
          end
          if (r >= 0) set_reply(r, $urandom);
        end
        default: ;
      endcase
      run_cycle();
    end

    // Asynchronous reset between clock edges.
    c_req_vld = '1;
    m_req_rdy = 1'b1;
    run_cycle();
    c_req_vld = '1;
    m_req_rdy = 1'b0;
    #3;
    i_rst = 1'b1;
    #1;
    check("arst_m_req_vld", 64'(m_req_vld), 64'(0));
    check("arst_m_req_data", 64'(m_req_data), 64'(0));
    check("arst_o_rep_err", 64'(o_rep_err), 64'(0));
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    idle_inputs();
    c_req_vld  = '1;
    c_req_data = NC*RW'({$urandom, $urandom});
    #1;
    check("arst_first_grant", 64'(c_req_rdy), 64'(1));
    run_cycle();
    for (int n = 0; n < 3; n++) begin
      c_req_vld = '1;
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
